// File: rtl/i281_run_ctrl.sv
`timescale 1ns/1ps
// i281_run_ctrl: run/halt/step/breakpoint controller for the i281 core.
// The core advances only on cycles where core_en is high. Breakpoints stop
// the core before the matching instruction executes.
//
// state       | meaning
// ST_HALTED   | core frozen; every command is accepted
// ST_RUNNING  | core free-runs until a breakpoint or HALT
// ST_STEPPING | core runs step_rem more instructions, then halts
module i281_run_ctrl #(
    parameter int PC_W   = 6,
    parameter int NUM_BP = 4,
    parameter int CYC_W  = 16,
    parameter int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic [CYC_W-1:0] cmd_arg,
    input  logic [PC_W-1:0]  pc,
    output logic             core_en,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [IDX_W-1:0] bp_hit_idx,
    output logic [CYC_W-1:0] instr_count
);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_HALT    = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_SET_BP  = 3'd4;
    localparam logic [2:0] OP_CLR_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_CNT = 3'd6;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_CMD  = 2'd1;
    localparam logic [1:0] CAUSE_STEP = 2'd2;
    localparam logic [1:0] CAUSE_BP   = 2'd3;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CYC_W-1:0] step_rem, step_rem_nxt;
    logic             skip, skip_nxt;
    logic [1:0]       cause_nxt;
    logic [IDX_W-1:0] hit_nxt;
    logic [CYC_W-1:0] count_nxt;

    logic [NUM_BP-1:0] bp_en;
    logic [PC_W-1:0]   bp_addr [NUM_BP];
    logic              bp_hit_any;
    logic [IDX_W-1:0]  bp_slot;
    logic              bp_match;
    logic              cmd_acc;
    logic              idx_ok;

    // Breakpoint compare; scanning downward leaves the lowest matching slot selected.
    always_comb begin
        bp_hit_any = 1'b0;
        bp_slot    = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (bp_addr[i] == pc)) begin
                bp_hit_any = 1'b1;
                bp_slot    = IDX_W'(i);
            end
        end
    end

    assign bp_match = bp_hit_any && !skip;
    assign core_en  = (state != ST_HALTED) && !bp_match;
    assign halted   = (state == ST_HALTED);
    assign cmd_acc  = cmd_valid && cmd_ready;
    assign idx_ok   = (int'(cmd_idx) < NUM_BP);

    // Command acceptance: anything while halted, only non-disruptive ops while the core moves.
    always_comb begin
        cmd_ready = 1'b1;
        if (state != ST_HALTED) begin
            cmd_ready = (cmd_op == OP_NOP) || (cmd_op == OP_HALT) ||
                        (cmd_op == OP_SET_BP) || (cmd_op == OP_CLR_BP);
        end
    end

    // Next-state logic; halt causes are tested in priority order breakpoint > step > HALT.
    always_comb begin
        state_nxt    = state;
        step_rem_nxt = step_rem;
        skip_nxt     = skip;
        cause_nxt    = halt_cause;
        hit_nxt      = bp_hit_idx;
        count_nxt    = instr_count;

        if (core_en) begin
            skip_nxt = 1'b0;
            if (instr_count != {CYC_W{1'b1}}) begin
                count_nxt = instr_count + CYC_W'(1);
            end
            if (state == ST_STEPPING) begin
                step_rem_nxt = step_rem - CYC_W'(1);
            end
        end

        case (state)
            ST_HALTED: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_nxt = ST_RUNNING;
                            skip_nxt  = 1'b1;
                        end
                        OP_STEP: begin
                            state_nxt    = ST_STEPPING;
                            step_rem_nxt = (cmd_arg == '0) ? CYC_W'(1) : cmd_arg;
                            skip_nxt     = 1'b1;
                        end
                        OP_CLR_CNT: count_nxt = '0;
                        default: ;
                    endcase
                end
            end
            ST_RUNNING, ST_STEPPING: begin
                if (bp_match) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_BP;
                    hit_nxt   = bp_slot;
                end else if ((state == ST_STEPPING) && core_en && (step_rem == CYC_W'(1))) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_STEP;
                end else if (cmd_acc && (cmd_op == OP_HALT)) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_CMD;
                end
            end
            default: state_nxt = ST_HALTED;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_HALTED;
            step_rem    <= '0;
            skip        <= 1'b0;
            halt_cause  <= CAUSE_NONE;
            bp_hit_idx  <= '0;
            instr_count <= '0;
        end else begin
            state       <= state_nxt;
            step_rem    <= step_rem_nxt;
            skip        <= skip_nxt;
            halt_cause  <= cause_nxt;
            bp_hit_idx  <= hit_nxt;
            instr_count <= count_nxt;
        end
    end

    // Breakpoint slots; writable in any state, visible to the compare from the next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            bp_en <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr[i] <= '0;
            end
        end else if (cmd_acc && idx_ok) begin
            if (cmd_op == OP_SET_BP) begin
                bp_en[cmd_idx]   <= 1'b1;
                bp_addr[cmd_idx] <= cmd_arg[PC_W-1:0];
            end else if (cmd_op == OP_CLR_BP) begin
                bp_en[cmd_idx] <= 1'b0;
            end
        end
    end

endmodule
